// File: rtl/usb_reg_bridge.sv
// SAM3U external-bus front end: synchronises RDn/WRn/CEn/ALEn, drives single-cycle register strobes.
// Optional idle-timeout abort enabled by defining USB_REG_BRIDGE_TIMEOUT_EN.
module usb_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned BCNT_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [7:0]        usb_din,
  output logic [7:0]        usb_dout,
  output logic              usb_doe,
  input  logic [7:0]        usb_addr,
  input  logic              usb_rdn,
  input  logic              usb_wrn,
  input  logic              usb_cen,
  input  logic              usb_alen,
  output logic [ADDR_W-1:0] reg_address,
  output logic [BCNT_W-1:0] reg_bytecnt,
  output logic [7:0]        reg_datao,
  input  logic [7:0]        reg_datai,
  output logic              reg_read,
  output logic              reg_write,
  output logic              reg_addrvalid,
  output logic [ADDR_W-1:0] reg_hypaddress,
  input  logic [15:0]       reg_hyplen,
  output logic [15:0]       reg_size,
  output logic              bus_error
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_WRITE, S_RD_STB, S_RD_DATA
  } state_t;

  state_t state_q, state_d;

  // Strobe vector order: {alen, cen, wrn, rdn}; all flops reset to inactive (high).
  logic [SYNC_N-1:0][3:0] sync_q;
  logic [3:0]             prev_q;
  logic [3:0]             s;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= {usb_alen, usb_cen, usb_wrn, usb_rdn};
      for (int unsigned i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_N-1];
    end
  end

  assign s = sync_q[SYNC_N-1];

  logic rd_s, cen_s, rd_fall, rd_rise, wr_rise, al_fall;
  assign rd_s    = s[0];
  assign cen_s   = s[2];
  assign rd_fall =  prev_q[0] & ~s[0];
  assign rd_rise = ~prev_q[0] &  s[0];
  assign wr_rise = ~prev_q[1] &  s[1];
  assign al_fall =  prev_q[3] & ~s[3];

  logic timeout;

`ifdef USB_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            to_active, any_edge;

  assign to_active = (state_q == S_WAIT) || (state_q == S_RD_STB) || (state_q == S_RD_DATA);
  assign any_edge  = |(prev_q ^ s);
  assign timeout   = to_active && !any_edge && (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d = '0;
    if (to_active && !any_edge) to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) to_q <= '0;
    else         to_q <= to_d;
  end
`else
  assign timeout = 1'b0;
`endif

  logic addr_ld, cnt_clr, cnt_inc, wdata_ld, rdata_ld, err_set;

  always_comb begin
    state_d  = state_q;
    addr_ld  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    wdata_ld = 1'b0;
    rdata_ld = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (al_fall && !cen_s) begin
          state_d = S_ADDR;
          addr_ld = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_ADDR: state_d = cen_s ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (cen_s) state_d = S_IDLE;
        else if (al_fall) begin
          state_d = S_ADDR;
          addr_ld = 1'b1;
          cnt_clr = 1'b1;
        end else if (wr_rise) begin
          // RDn low at the same time as a write completes: the write is taken, the read dropped.
          state_d  = S_WRITE;
          wdata_ld = 1'b1;
          err_set  = ~rd_s;
        end else if (rd_fall) state_d = S_RD_STB;
        else if (timeout) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_WRITE: begin
        cnt_inc = 1'b1;
        if (cen_s) state_d = S_IDLE;
        else if (al_fall) begin
          state_d = S_ADDR;
          addr_ld = 1'b1;
          cnt_clr = 1'b1;
        end else state_d = S_WAIT;
      end
      S_RD_STB, S_RD_DATA: begin
        if (cen_s) state_d = S_IDLE;
        else if (al_fall) begin
          state_d = S_ADDR;
          addr_ld = 1'b1;
          cnt_clr = 1'b1;
          err_set = 1'b1;
        end else if (rd_rise) begin
          state_d = S_WAIT;
          cnt_inc = 1'b1;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end else if (state_q == S_RD_STB) begin
          state_d  = S_RD_DATA;
          rdata_ld = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  logic [ADDR_W-1:0] addr_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [7:0]        datao_q, dout_q;
  logic [15:0]       size_q;
  logic              err_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      bcnt_q  <= '0;
      datao_q <= '0;
      dout_q  <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      size_q <= reg_hyplen;
      if (addr_ld)  addr_q  <= usb_addr[ADDR_W-1:0];
      if (cnt_clr)      bcnt_q <= '0;
      else if (cnt_inc) bcnt_q <= bcnt_q + BCNT_W'(1);
      if (wdata_ld) datao_q <= usb_din;
      if (rdata_ld) dout_q  <= reg_datai;
      if (err_set)  err_q   <= 1'b1;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^usb_addr;

  assign reg_read       = (state_q == S_RD_STB);
  assign reg_write      = (state_q == S_WRITE);
  assign usb_doe        = (state_q == S_RD_DATA);
  assign usb_dout       = usb_doe ? dout_q : '0;
  assign reg_addrvalid  = (state_q == S_WAIT) || (state_q == S_WRITE) ||
                          (state_q == S_RD_STB) || (state_q == S_RD_DATA);
  assign reg_address    = addr_q;
  assign reg_hypaddress = addr_q;
  assign reg_bytecnt    = bcnt_q;
  assign reg_datao      = datao_q;
  assign reg_size       = size_q;
  assign bus_error      = err_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Scoreboard bench for usb_reg_bridge: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_usb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  usb_din, usb_dout, usb_addr, reg_datao, reg_datai;
  logic        usb_doe, usb_rdn, usb_wrn, usb_cen, usb_alen;
  logic [5:0]  reg_address, reg_hypaddress;
  logic [15:0] reg_bytecnt, reg_hyplen, reg_size;
  logic        reg_read, reg_write, reg_addrvalid, bus_error;

  usb_reg_bridge #(.SYNC_STAGES(2), .ADDR_W(6), .BCNT_W(16), .TIMEOUT_CYC(1023)) dut (
    .clk(clk), .reset_i(reset_i), .usb_din(usb_din), .usb_dout(usb_dout), .usb_doe(usb_doe),
    .usb_addr(usb_addr), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
    .usb_alen(usb_alen), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
    .reg_size(reg_size), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned addr;
    int unsigned cnt;
    int unsigned data;
    int unsigned cyc;
  } exp_t;

  exp_t        wq[$];
  exp_t        rq[$];
  int unsigned fq[$];

  // Reference model of the bus-visible register-side state.
  int unsigned m_addr = 0;
  int unsigned m_cnt  = 0;
  int unsigned m_err  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or changes output enable.
  logic        doe_prev = 1'b0;
  logic        doe_pend = 1'b0;
  int unsigned exp_dout = 0;
  int unsigned exp_doe_cyc = 0;

  always @(negedge clk) begin
    if (reset_i) begin
      doe_prev = 1'b0;
      doe_pend = 1'b0;
    end else begin
      if (reg_write) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          exp_t e;
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", reg_address, e.addr);
          chk("wr_bytecnt", reg_bytecnt, e.cnt);
          chk("wr_datao", reg_datao, e.data);
        end
      end
      if (reg_read) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          exp_t e;
          e = rq.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", reg_address, e.addr);
          chk("rd_bytecnt", reg_bytecnt, e.cnt);
          exp_dout    = e.data;
          exp_doe_cyc = cyc + 1;
          doe_pend    = 1'b1;
        end
      end
      if (usb_doe && !doe_prev) begin
        chk("doe_rise_expected", doe_pend, 1);
        chk("doe_rise_cycle", cyc, exp_doe_cyc);
        chk("rd_dout", usb_dout, exp_dout);
        doe_pend = 1'b0;
      end
      if (!usb_doe && doe_prev) begin
        if (fq.size() == 0) chk("unexpected_doe_fall", 1, 0);
        else chk("doe_fall_cycle", cyc, fq.pop_front());
      end
      doe_prev = usb_doe;
    end
  end

  task automatic do_addr(input logic [7:0] a);
    usb_addr = a;
    usb_alen = 1'b0;
    tick($urandom_range(4, 8));
    usb_alen = 1'b1;
    m_addr = a & 8'h3f;
    m_cnt  = 0;
    tick($urandom_range(4, 8));
  endtask

  task automatic do_write(input logic [7:0] d);
    exp_t e;
    usb_din = d;
    usb_wrn = 1'b0;
    tick($urandom_range(4, 8));
    usb_wrn = 1'b1;
    e = '{addr: m_addr, cnt: m_cnt, data: d, cyc: cyc + 3};
    wq.push_back(e);
    m_cnt = (m_cnt + 1) % 65536;
    tick($urandom_range(4, 8));
  endtask

  task automatic do_read(input logic [7:0] d);
    exp_t e;
    reg_datai = d;
    usb_rdn   = 1'b0;
    e = '{addr: m_addr, cnt: m_cnt, data: d, cyc: cyc + 3};
    rq.push_back(e);
    tick($urandom_range(4, 8));
    usb_rdn = 1'b1;
    fq.push_back(cyc + 3);
    m_cnt = (m_cnt + 1) % 65536;
    tick($urandom_range(4, 8));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addrvalid"}, reg_addrvalid, 1);
    chk({tag, "_address"}, reg_address, m_addr);
    chk({tag, "_hypaddress"}, reg_hypaddress, m_addr);
    chk({tag, "_bytecnt"}, reg_bytecnt, m_cnt);
    chk({tag, "_bus_error"}, bus_error, m_err);
    chk({tag, "_doe"}, usb_doe, 0);
  endtask

  initial begin
    reset_i    = 1'b1;
    usb_din    = 8'h00;
    usb_addr   = 8'h00;
    usb_rdn    = 1'b1;
    usb_wrn    = 1'b1;
    usb_cen    = 1'b1;
    usb_alen   = 1'b1;
    reg_datai  = 8'h00;
    reg_hyplen = 16'h1234;
    tick(3);
    chk("rst_dout", usb_dout, 0);
    chk("rst_doe", usb_doe, 0);
    chk("rst_address", reg_address, 0);
    chk("rst_bytecnt", reg_bytecnt, 0);
    chk("rst_datao", reg_datao, 0);
    chk("rst_read", reg_read, 0);
    chk("rst_write", reg_write, 0);
    chk("rst_addrvalid", reg_addrvalid, 0);
    chk("rst_size", reg_size, 0);
    chk("rst_bus_error", bus_error, 0);
    reset_i = 1'b0;
    tick(2);
    chk("size_follow", reg_size, 16'h1234);
    usb_cen = 1'b0;
    tick(5);

    // Write burst then a fourth access (read), then a new address clears the byte counter.
    do_addr(8'h12);
    do_write(8'hA1);
    do_write(8'hB2);
    do_write(8'hC3);
    check_idle("burst");
    do_read(8'h3C);
    check_idle("burst_rd");
    do_addr(8'h20);
    check_idle("newaddr");
    do_addr(8'h05);
    do_read(8'h5A);
    check_idle("read");

    // Randomised traffic against the model.
    for (int unsigned i = 0; i < 40; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op < 2)      do_addr(8'($urandom));
      else if (op < 6) do_write(8'($urandom));
      else             do_read(8'($urandom));
      if (op == 0) begin
        reg_hyplen = 16'($urandom);
        tick(2);
        chk("size_rand", reg_size, reg_hyplen);
      end
    end
    check_idle("random");

    // Write completing on the same synced cycle that RDn falls: write only, error set.
    begin
      exp_t e;
      do_addr(8'h2A);
      usb_din = 8'h77;
      usb_wrn = 1'b0;
      tick(5);
      usb_wrn = 1'b1;
      usb_rdn = 1'b0;
      e = '{addr: m_addr, cnt: m_cnt, data: 8'h77, cyc: cyc + 3};
      wq.push_back(e);
      m_cnt = m_cnt + 1;
      m_err = 1;
      tick(8);
      usb_rdn = 1'b1;
      tick(6);
      check_idle("collision");
    end

    // ALEn falling during an active read aborts it and moves to the new address.
    begin
      exp_t e;
      do_addr(8'h11);
      reg_datai = 8'h96;
      usb_rdn = 1'b0;
      e = '{addr: m_addr, cnt: m_cnt, data: 8'h96, cyc: cyc + 3};
      rq.push_back(e);
      tick(6);
      usb_addr = 8'h3E;
      usb_alen = 1'b0;
      fq.push_back(cyc + 3);
      tick(5);
      usb_alen = 1'b1;
      m_addr = 8'h3E;
      m_cnt  = 0;
      tick(4);
      usb_rdn = 1'b1;
      tick(6);
      check_idle("abort");
    end

    // CEn high drops to IDLE, keeps the address and ignores strobes.
    usb_cen = 1'b1;
    tick(6);
    chk("cen_addrvalid", reg_addrvalid, 0);
    chk("cen_address", reg_address, m_addr);
    usb_wrn = 1'b0;
    tick(5);
    usb_wrn = 1'b1;
    tick(6);
    chk("cen_bytecnt", reg_bytecnt, m_cnt);
    usb_cen = 1'b0;
    tick(5);
    chk("cen_idle_addrvalid", reg_addrvalid, 0);

    // Reset while the pad is driven.
    do_addr(8'h33);
    reg_datai = 8'hE1;
    begin
      exp_t e;
      e = '{addr: m_addr, cnt: m_cnt, data: 8'hE1, cyc: cyc + 3};
      rq.push_back(e);
    end
    usb_rdn = 1'b0;
    tick(6);
    chk("pre_rst_doe", usb_doe, 1);
    #1 reset_i = 1'b1;
    #1;
    chk("async_rst_doe", usb_doe, 0);
    chk("async_rst_dout", usb_dout, 0);
    chk("async_rst_addrvalid", reg_addrvalid, 0);
    chk("async_rst_address", reg_address, 0);
    chk("async_rst_bus_error", bus_error, 0);
    tick(2);
    reset_i = 1'b0;
    m_addr = 0;
    m_cnt  = 0;
    m_err  = 0;
    tick(4);
    usb_rdn = 1'b1;
    tick(4);
    usb_wrn = 1'b0;
    tick(5);
    usb_wrn = 1'b1;
    tick(8);
    chk("post_rst_addrvalid", reg_addrvalid, 0);
    chk("post_rst_bytecnt", reg_bytecnt, 0);
    do_addr(8'h09);
    do_write(8'h5C);
    do_read(8'hC5);
    check_idle("post_rst");
    tick(10);

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_reg_bridge.md
Name: usb_reg_bridge

Overview:
- Front end between the SAM3U external-bus pins (USB_D/Addr/RDn/WRn/CEn/ALEn) and the shared internal register bus that every reg_* block decodes.
- Synchronises the asynchronous bus strobes into `clk` and latches address and data.
- Generates single-cycle `reg_read`/`reg_write` strobes, maintains the per-address byte counter and returns read data to the pins.
- The top level owns the tristate; this block supplies data-out plus output-enable.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for RDn/WRn/CEn/ALEn (min 2).
- ADDR_W, 6, width of `reg_address` (low bits of USB_Addr).
- BCNT_W, 16, byte-counter width.
- TIMEOUT_CYC, 1023, idle cycles before abort (optional feature only).

Ports:
- clk  in  1  interface clock (96 MHz PLL-buffered USB clock).
- reset_i  in  1  asynchronous, active-high reset.
- usb_din  in  8  USB_D as sampled from pad.
- usb_dout  out  8  read data to pad.
- usb_doe  out  1  pad output enable.
- usb_addr  in  8  USB_Addr.
- usb_rdn  in  1  read strobe, active low.
- usb_wrn  in  1  write strobe, active low.
- usb_cen  in  1  chip enable, active low.
- usb_alen  in  1  address latch enable, active low.
- reg_address  out  ADDR_W  latched register address.
- reg_bytecnt  out  BCNT_W  byte index within current address.
- reg_datao  out  8  write data to register blocks.
- reg_datai  in  8  OR-combined read data from register blocks.
- reg_read  out  1  one-cycle read strobe.
- reg_write  out  1  one-cycle write strobe.
- reg_addrvalid  out  1  address latched and CEn low.
- reg_hypaddress  out  ADDR_W  address presented for length lookup (= reg_address).
- reg_hyplen  in  16  length of addressed register.
- reg_size  out  16  registered copy of `reg_hyplen`.
- bus_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - synchroniser flops reset to 1 (strobes inactive).
- Strobes pass SYNC_STAGES flops, then one edge-detect flop.
  - A pin edge is acted on SYNC_STAGES+1 cycles after it occurs.
- `usb_addr` and `usb_din` are sampled on the same cycle the synced edge is detected. Board guarantees setup.
- FSM states:
  - IDLE → ADDR on synced ALEn falling edge with CEn low.
  - ADDR: latch `reg_address` = usb_addr[ADDR_W-1:0]; clear `reg_bytecnt`; → WAIT.
  - WAIT:
    - synced WRn rising edge → WRITE;
    - synced RDn falling edge → READ;
    - ALEn falling edge → ADDR;
    - CEn high → IDLE.
  - WRITE: `reg_datao` = usb_din; `reg_write`=1 for one cycle; `reg_bytecnt` increments the following cycle; → WAIT.
  - READ:
    - cycle 0: `reg_read`=1 for one cycle;
    - cycle 1: `usb_dout` ← reg_datai, `usb_doe`=1;
    - stays until synced RDn rising edge, then `usb_doe`=0, `reg_bytecnt` increments, → WAIT.
- `reg_addrvalid` = 1 in WAIT/WRITE/READ, 0 in IDLE/ADDR.
- `reg_size` updates every cycle from `reg_hyplen`.
- `reg_bytecnt` wraps modulo 2^BCNT_W silently. Size checking is the register block's job.
- Simultaneous synced RDn-low and WRn-rising in WAIT:
  - write wins;
  - `bus_error` sets;
  - the read is ignored.
- ALEn falling edge while in READ: abort the read (`usb_doe`=0), no bytecnt increment, → ADDR, `bus_error` sets.
- CEn rising in any non-IDLE state → IDLE next cycle, `usb_doe`=0, `reg_address` retained.
- `bus_error` clears only on reset_i.
- reset_i asserted mid-access:
  - all outputs 0 immediately (async);
  - after release the FSM waits in IDLE for a fresh ALEn edge. A pending RDn/WRn is ignored.

Optional Feature:
- Macro: USB_REG_BRIDGE_TIMEOUT_EN.
- Defined:
  - a counter runs in WAIT and READ and resets on any synced strobe edge;
  - reaching TIMEOUT_CYC forces IDLE, `usb_doe`=0, and sets `bus_error`.
- Undefined: no counter; the FSM can remain in WAIT/READ indefinitely while CEn is low.

Test Plan:
- Write burst:
  - Stimulus: CEn=0, ALEn pulse with addr 0x12, then 3 WRn pulses with data 0xA1, 0xB2, 0xC3.
  - Response: reg_address=0x12; three 1-cycle reg_write pulses with reg_datao=A1/B2/C3 and reg_bytecnt=0/1/2.
- Read:
  - Stimulus: addr 0x05, reg_datai=0x5A, one RDn pulse.
  - Response: reg_read pulse 3 cycles after RDn falls; usb_doe=1 with usb_dout=0x5A until 3 cycles after RDn rises; bytecnt becomes 1.
- New address:
  - Stimulus: ALEn pulse with addr 0x20 after 4 accesses to 0x12.
  - Response: reg_bytecnt returns to 0 and reg_address=0x20.
- Collision:
  - Stimulus: WRn rising while RDn is held low.
  - Response: reg_write=1, reg_read stays 0, bus_error=1.
- Reset during read:
  - Stimulus: assert reset_i while usb_doe=1.
  - Response: usb_doe=0 asynchronously; no strobes until the next ALEn edge.
- Timeout (USB_REG_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=15):
  - Stimulus: CEn low, ALEn latched, then no strobes.
  - Response: returns to IDLE after 15 cycles in WAIT; bus_error=1; reg_addrvalid=0.
